mul_wb_arbiter: RTL and testbench

//  - Receiving end of the multiply pipeline: takes results leaving the last mul stage (M5) and merges them with
//    ALU writebacks onto the single register-file write port.
//  - ALU has priority. Mul results that cannot write immediately are queued in a small in-order FIFO.
//  - Asserts mul_stall back to the mul pipe when the queue is full.
//  - Sits between the M-stage chain / EX-MEM path and the register file (WB stage).

---
 rtl/mul_wb_arbiter_pkg.sv | 33 +++
 rtl/mul_wb_arbiter_if.sv | 33 +++
 rtl/mul_wb_arbiter_wb_fifo.sv | 103 ++++++++++
 rtl/mul_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_mul_wb_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_wb_arbiter_pkg.sv
// Shared definitions for the multiply writeback arbiter: datapath widths,
// the FIFO entry layout, the write-port source select and a small dst helper.
package mul_wb_arbiter_pkg;

    localparam int REG_SIZE   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 4;

    localparam logic [REG_ADDR_W-1:0] R0 = 5'd0;

    // One queued mul result; valid=0 marks an entry killed by a younger ALU write.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_SIZE-1:0]   data;
    } wb_entry_t;

    localparam wb_entry_t ENTRY_RESET = '{valid: 1'b0, dst: 5'd0, data: {REG_SIZE{1'b0}}};

    // Which producer owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE   = 2'd0,
        WB_SRC_ALU    = 2'd1,
        WB_SRC_HEAD   = 2'd2,
        WB_SRC_BYPASS = 2'd3
    } wb_src_e;

    // Writes to r0 are architecturally discarded.
    function automatic logic dst_live(input logic [REG_ADDR_W-1:0] dst);
        return (dst != R0);
    endfunction

endpackage

// File: rtl/mul_wb_arbiter_if.sv
// Bus bundle between the M5 stage / EX-MEM path and the writeback arbiter.
// master = producer side (mul pipe + ALU), slave = the arbiter.
interface mul_wb_arbiter_if;
    import mul_wb_arbiter_pkg::*;

    logic                  mul_valid;
    logic [REG_SIZE-1:0]   mul_result;
    logic                  mul_overflow;
    logic [REG_ADDR_W-1:0] mul_dst;
    logic                  mul_stall;
    logic                  alu_wen;
    logic [REG_SIZE-1:0]   alu_result;
    logic [REG_ADDR_W-1:0] alu_dst;
    logic                  rf_wen;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [REG_SIZE-1:0]   rf_wdata;
    logic                  mul_exc;
    logic [REG_ADDR_W-1:0] mul_exc_dst;
    logic                  pending;

    modport master (
        output mul_valid, mul_result, mul_overflow, mul_dst,
        output alu_wen, alu_result, alu_dst,
        input  mul_stall, rf_wen, rf_waddr, rf_wdata, mul_exc, mul_exc_dst, pending
    );

    modport slave (
        input  mul_valid, mul_result, mul_overflow, mul_dst,
        input  alu_wen, alu_result, alu_dst,
        output mul_stall, rf_wen, rf_waddr, rf_wdata, mul_exc, mul_exc_dst, pending
    );

endinterface

// File: rtl/mul_wb_arbiter_wb_fifo.sv
// In-order queue of mul results waiting for the register-file port.
// Entries carry a valid bit that a younger ALU write to the same dst clears;
// killed entries keep their slot and are retired by a normal pop.
module wb_fifo
    import mul_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  wb_entry_t                push_entry_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [REG_ADDR_W-1:0]    kill_dst_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [DEPTH-1:0]     kill_vec_s;

    // Per-entry dst compare against the ALU writeback destination.
    always_comb begin
        kill_vec_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_q[i].dst == kill_dst_i)) begin
                kill_vec_s[i] = 1'b1;
            end else begin
                kill_vec_s[i] = 1'b0;
            end
        end
    end

    // Pointer and occupancy next-state; push and pop in one cycle leave count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: kills first, then pop clears the head, then the push lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_RESET;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_vec_s[i]) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (pop_i) begin
                mem_q[rd_ptr_q].valid <= 1'b0;
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter: merges M5 multiply results with ALU writebacks onto the
// single register-file write port. ALU wins; mul results wait in wb_fifo and
// retire in arrival order. Overflowing muls raise mul_exc instead of writing.
module mul_wb_arbiter
    import mul_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = mul_wb_arbiter_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    mul_wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t             head_s;
    wb_entry_t             push_entry_s;
    logic [CNT_W-1:0]      count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  accept_s;
    logic                  mul_ok_s;
    logic                  alu_kill_s;
    logic                  push_s;
    logic                  pop_s;
    wb_src_e               src_s;

    logic                  rf_wen_q;
    logic                  rf_wen_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [REG_ADDR_W-1:0] rf_waddr_d;
    logic [REG_SIZE-1:0]   rf_wdata_q;
    logic [REG_SIZE-1:0]   rf_wdata_d;
    logic                  mul_exc_q;
    logic                  mul_exc_d;
    logic [REG_ADDR_W-1:0] mul_exc_dst_q;
    logic [REG_ADDR_W-1:0] mul_exc_dst_d;

    // Stall comes from the registered count so the mul pipe sees no comb loop.
    assign full_s     = (count_s == CNT_W'(DEPTH));
    assign empty_s    = (count_s == {CNT_W{1'b0}});
    assign accept_s   = bus.mul_valid & ~full_s;
    assign mul_ok_s   = accept_s & ~bus.mul_overflow & dst_live(bus.mul_dst);
    assign alu_kill_s = bus.alu_wen & dst_live(bus.alu_dst);

    // A same-cycle ALU write to the mul's dst is younger, so the mul enters killed.
    assign push_entry_s = '{valid: ~(alu_kill_s & (bus.alu_dst == bus.mul_dst)),
                            dst:   bus.mul_dst,
                            data:  bus.mul_result};

    // Port owner: ALU, else queue head (killed heads pop silently), else bypass.
    always_comb begin
        src_s = WB_SRC_NONE;
        pop_s = 1'b0;
        if (bus.alu_wen) begin
            src_s = WB_SRC_ALU;
        end else if (!empty_s) begin
            pop_s = 1'b1;
            if (head_s.valid) begin
                src_s = WB_SRC_HEAD;
            end else begin
                src_s = WB_SRC_NONE;
            end
        end else if (mul_ok_s) begin
            src_s = WB_SRC_BYPASS;
        end else begin
            src_s = WB_SRC_NONE;
        end
    end

    // Any live mul that did not take the port directly joins the queue tail.
    assign push_s = mul_ok_s & (src_s != WB_SRC_BYPASS);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .kill_i       (alu_kill_s),
        .kill_dst_i   (bus.alu_dst),
        .head_o       (head_s),
        .count_o      (count_s)
    );

    // Next values of the write port and the overflow exception pulse.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = R0;
        rf_wdata_d = {REG_SIZE{1'b0}};
        case (src_s)
            WB_SRC_ALU: begin
                if (dst_live(bus.alu_dst)) begin
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = bus.alu_dst;
                    rf_wdata_d = bus.alu_result;
                end else begin
                    rf_wen_d   = 1'b0;
                end
            end
            WB_SRC_HEAD: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = head_s.dst;
                rf_wdata_d = head_s.data;
            end
            WB_SRC_BYPASS: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = bus.mul_dst;
                rf_wdata_d = bus.mul_result;
            end
            default: begin
                rf_wen_d   = 1'b0;
            end
        endcase
        mul_exc_d = accept_s & bus.mul_overflow;
        if (mul_exc_d) begin
            mul_exc_dst_d = bus.mul_dst;
        end else begin
            mul_exc_dst_d = R0;
        end
    end

    // Registered write port and exception outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wen_q      <= 1'b0;
            rf_waddr_q    <= R0;
            rf_wdata_q    <= {REG_SIZE{1'b0}};
            mul_exc_q     <= 1'b0;
            mul_exc_dst_q <= R0;
        end else begin
            rf_wen_q      <= rf_wen_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            mul_exc_q     <= mul_exc_d;
            mul_exc_dst_q <= mul_exc_dst_d;
        end
    end

    assign bus.rf_wen      = rf_wen_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.mul_exc     = mul_exc_q;
    assign bus.mul_exc_dst = mul_exc_dst_q;
    assign bus.mul_stall   = full_s;
    assign bus.pending     = ~empty_s;

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Scenario bench for mul_wb_arbiter: expected register-file writes are queued
// as stimulus is driven and popped when the write port produces them.
module tb_mul_wb_arbiter;
    import mul_wb_arbiter_pkg::*;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];

    mul_wb_arbiter_if bus ();

    mul_wb_arbiter #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.mul_valid    = 1'b0;
        bus.mul_result   = 32'd0;
        bus.mul_overflow = 1'b0;
        bus.mul_dst      = 5'd0;
        bus.alu_wen      = 1'b0;
        bus.alu_result   = 32'd0;
        bus.alu_dst      = 5'd0;
    endtask

    task automatic drive_alu(input logic [4:0] d, input logic [31:0] v);
        bus.alu_wen    = 1'b1;
        bus.alu_dst    = d;
        bus.alu_result = v;
    endtask

    task automatic drive_mul(input logic [4:0] d, input logic [31:0] v, input logic ovf);
        bus.mul_valid    = 1'b1;
        bus.mul_dst      = d;
        bus.mul_result   = v;
        bus.mul_overflow = ovf;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_inputs();
        tick(); tick();
        n_vec++;
        if ({bus.rf_wen, bus.mul_exc, bus.pending, bus.mul_stall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got wen/exc/pend/stall=%b want 0000",
                     {bus.rf_wen, bus.mul_exc, bus.pending, bus.mul_stall});
        end
        n_vec++;
        if (bus.rf_waddr !== 5'd0 || bus.mul_exc_dst !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got waddr=%0d exc_dst=%0d want 0/0", bus.rf_waddr, bus.mul_exc_dst);
        end
        n_vec++;
        if (bus.rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_lone_mul;
        wr_t e;
        exp_q.delete();
        drive_mul(5'd5, 32'h12345678, 1'b0);
        exp_q.push_back('{5'd5, 32'h12345678});
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        n_vec++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
            n_fail++;
            $display("FAIL lone_mul: got wen=%b r%0d=%h want wen=1 r%0d=%h",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
        end
        n_vec++;
        if (bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_mul_pending: got %b want 0", bus.pending);
        end
        tick();
        n_vec++;
        if (bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_mul_once: got wen=%b want 0", bus.rf_wen);
        end
    endtask

    task automatic test_alu_and_mul;
        wr_t e;
        exp_q.delete();
        drive_alu(5'd3, 32'h0000000A);
        drive_mul(5'd4, 32'h0000000B, 1'b0);
        exp_q.push_back('{5'd3, 32'h0000000A});
        exp_q.push_back('{5'd4, 32'h0000000B});
        for (int c = 0; c < 2; c++) begin
            tick();
            idle_inputs();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
                n_fail++;
                $display("FAIL alu_mul_c%0d: got wen=%b r%0d=%h want wen=1 r%0d=%h",
                         c + 1, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
            end
            n_vec++;
            if (bus.pending !== (c == 0)) begin
                n_fail++;
                $display("FAIL alu_mul_pending_c%0d: got %b want %b", c + 1, bus.pending, c == 0);
            end
        end
    endtask

    task automatic test_back_to_back;
        wr_t  e;
        int   acc;
        logic stall_exp;
        exp_q.delete();
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            idle_inputs();
            stall_exp = (c >= 4 && c <= 6);
            if (c < 6) begin
                drive_alu(5'd20, 32'(32'hA0 + c));
                exp_q.push_back('{5'd20, 32'(32'hA0 + c)});
            end
            if (c == 6) begin
                for (int k = 0; k < 5; k++) exp_q.push_back('{5'(k + 1), 32'(32'h100 + k)});
            end
            n_vec++;
            if (bus.mul_stall !== stall_exp) begin
                n_fail++;
                $display("FAIL b2b_stall_c%0d: got %b want %b", c, bus.mul_stall, stall_exp);
            end
            if (acc < 5) begin
                drive_mul(5'(acc + 1), 32'(32'h100 + acc), 1'b0);
                if (!stall_exp) acc++;
            end
            tick();
            if (bus.rf_wen === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_write: got r%0d=%h want no write", bus.rf_waddr, bus.rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
                        n_fail++;
                        $display("FAIL b2b_order: got r%0d=%h want r%0d=%h",
                                 bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
                    end
                end
            end
        end
        idle_inputs();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing: got %0d writes outstanding want 0", exp_q.size());
        end
        n_vec++;
        if (bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %b want 0", bus.pending);
        end
    endtask

    task automatic test_waw_kill;
        wr_t e;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            case (c)
                0: begin drive_alu(5'd20, 32'h000000B0); drive_mul(5'd7, 32'h00000077, 1'b0);
                         exp_q.push_back('{5'd20, 32'h000000B0}); end
                1: begin drive_alu(5'd7, 32'h00000099); exp_q.push_back('{5'd7, 32'h00000099}); end
                3: begin drive_alu(5'd8, 32'h00000055); drive_mul(5'd8, 32'h00000066, 1'b0);
                         exp_q.push_back('{5'd8, 32'h00000055}); end
                default: ;
            endcase
            tick();
            if (c == 0 || c == 1 || c == 3) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL waw_write_c%0d: got wen=%b r%0d=%h want wen=1 r%0d=%h",
                             c, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
                end
            end else begin
                n_vec++;
                if (bus.rf_wen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL waw_killed_c%0d: got wen=%b r%0d=%h want wen=0",
                             c, bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
                end
            end
            n_vec++;
            if (bus.pending !== (c == 0 || c == 1 || c == 3)) begin
                n_fail++;
                $display("FAIL waw_pending_c%0d: got %b want %b", c, bus.pending, (c == 0 || c == 1 || c == 3));
            end
        end
        idle_inputs();
    endtask

    task automatic test_overflow;
        wr_t e;
        exp_q.delete();
        drive_alu(5'd20, 32'h000000C0);
        drive_mul(5'd11, 32'h00000011, 1'b0);
        exp_q.push_back('{5'd20, 32'h000000C0});
        tick();
        e = exp_q.pop_front();
        n_vec++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
            n_fail++;
            $display("FAIL ovf_alu0: got wen=%b r%0d=%h want r%0d=%h", bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
        end
        idle_inputs();
        drive_alu(5'd21, 32'h000000C1);
        drive_mul(5'd9, 32'h0000DEAD, 1'b1);
        exp_q.push_back('{5'd21, 32'h000000C1});
        exp_q.push_back('{5'd11, 32'h00000011});
        tick();
        idle_inputs();
        n_vec++;
        if (bus.mul_exc !== 1'b1 || bus.mul_exc_dst !== 5'd9) begin
            n_fail++;
            $display("FAIL ovf_exc: got exc=%b dst=%0d want exc=1 dst=9", bus.mul_exc, bus.mul_exc_dst);
        end
        for (int c = 0; c < 2; c++) begin
            if (c == 1) tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.dst || bus.rf_wdata !== e.data) begin
                n_fail++;
                $display("FAIL ovf_write_%0d: got wen=%b r%0d=%h want r%0d=%h",
                         c, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.dst, e.data);
            end
        end
        n_vec++;
        if (bus.mul_exc !== 1'b0 || bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pulse: got exc=%b pending=%b want 0/0", bus.mul_exc, bus.pending);
        end
        drive_mul(5'd9, 32'h00000123, 1'b1);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.mul_exc !== 1'b1 || bus.mul_exc_dst !== 5'd9 || bus.rf_wen !== 1'b0 || bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_lone: got exc=%b dst=%0d wen=%b pend=%b want 1/9/0/0",
                     bus.mul_exc, bus.mul_exc_dst, bus.rf_wen, bus.pending);
        end
        tick();
    endtask

    task automatic test_r0;
        drive_mul(5'd0, 32'h00000005, 1'b0);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.rf_wen !== 1'b0 || bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_mul: got wen=%b pending=%b want 0/0", bus.rf_wen, bus.pending);
        end
        drive_alu(5'd0, 32'h00000006);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_alu: got wen=%b want 0", bus.rf_wen);
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            drive_alu(5'd20, 32'(32'hE0 + c));
            drive_mul(5'(c + 1), 32'(32'h200 + c), 1'b0);
            tick();
            n_vec++;
            if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'(32'hE0 + c)) begin
                n_fail++;
                $display("FAIL rstmid_alu_c%0d: got wen=%b data=%h want 1/%h", c, bus.rf_wen, bus.rf_wdata, 32'(32'hE0 + c));
            end
        end
        idle_inputs();
        drive_alu(5'd21, 32'h000000EE);
        n_vec++;
        if (bus.pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_filled: got pending=%b want 1", bus.pending);
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.rf_wen, bus.mul_exc, bus.pending, bus.mul_stall} !== 4'b0000 || bus.rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got wen/exc/pend/stall=%b data=%h want 0000/0",
                     {bus.rf_wen, bus.mul_exc, bus.pending, bus.mul_stall}, bus.rf_wdata);
        end
        idle_inputs();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++;
            if (bus.rf_wen !== 1'b0 || bus.pending !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale_c%0d: got wen=%b r%0d pend=%b want 0/0",
                         c, bus.rf_wen, bus.rf_waddr, bus.pending);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_lone_mul();
        test_alu_and_mul();
        test_back_to_back();
        test_waw_kill();
        test_overflow();
        test_r0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
